rdm_fifo: RTL and testbench

RDM_FIFO -- requirements
Module: rdm_fifo

---
 rtl/rdm_fifo.sv | 104 ++++++++++
 tb/tb_rdm_fifo.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rdm_fifo.sv
// Synchronous circular-buffer FIFO with a registered output word, sticky
// overflow/underflow flags and a synchronous flush.
module rdm_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] d,
  input  logic             rd_en,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             ovf,
  output logic             unf
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_q;
  logic             r_q_valid;
  logic             r_ovf;
  logic             r_unf;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  // Status decodes only from the registered count, never from the requests.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push.
  assign w_pop  = rd_en && !w_empty;
  assign w_push = wr_en && (!w_full || w_pop);

  // NOTE: storage has no reset; a word is only read after it was written,
  // so leaving it unreset keeps it a plain RAM with no reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem[r_wp] <= d;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp      <= '0;
      r_rp      <= '0;
      r_count   <= '0;
      r_q       <= '0;
      r_q_valid <= 1'b0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else if (flush) begin
      r_wp      <= '0;
      r_rp      <= '0;
      r_count   <= '0;
      r_q_valid <= 1'b0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      r_q_valid <= w_pop;
      if (w_push) begin
        r_wp <= r_wp + AW'(1);
      end
      if (w_pop) begin
        r_q  <= r_mem[r_rp];
        r_rp <= r_rp + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
      if (wr_en && !w_push) begin
        r_ovf <= 1'b1;
      end
      if (rd_en && w_empty) begin
        r_unf <= 1'b1;
      end
    end
  end

  assign q       = r_q;
  assign q_valid = r_q_valid;
  assign full    = w_full;
  assign empty   = w_empty;
  assign count   = r_count;
  assign ovf     = r_ovf;
  assign unf     = r_unf;

endmodule

// File: tb/tb_rdm_fifo.sv
// Self-checking bench for rdm_fifo: a queue-based reference model compared
// every cycle, plus literal expectations for the directed scenarios.
module tb_rdm_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] d = '0;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             ovf;
  logic             unf;

  rdm_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .wr_en   (wr_en),
    .d       (d),
    .rd_en   (rd_en),
    .q       (q),
    .q_valid (q_valid),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .ovf     (ovf),
    .unf     (unf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: contents as a queue, plus the visible output state.
  logic [WIDTH-1:0] m_fifo [$];
  logic [WIDTH-1:0] m_q   = '0;
  logic             m_qv  = 1'b0;
  logic             m_ovf = 1'b0;
  logic             m_unf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_q   = '0;
    m_qv  = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Applies one clock edge of the requests to the model.
  task automatic model_step(input logic w, input logic r, input logic f, input logic [WIDTH-1:0] dv);
    bit pop_ok;
    bit push_ok;
    if (!rst) return;
    if (f) begin
      m_fifo.delete();
      m_qv  = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      return;
    end
    pop_ok  = r && (m_fifo.size() > 0);
    push_ok = w && (m_fifo.size() < DEPTH || pop_ok);
    if (r && m_fifo.size() == 0) m_unf = 1'b1;
    if (w && !push_ok)           m_ovf = 1'b1;
    m_qv = pop_ok;
    if (pop_ok)  m_q = m_fifo.pop_front();
    if (push_ok) m_fifo.push_back(dv);
  endtask

  task automatic compare_model();
    int sz = m_fifo.size();
    check("q",       32'(q),       32'(m_q));
    check("q_valid", 32'(q_valid), 32'(m_qv));
    check("count",   32'(count),   32'(sz));
    check("full",    32'(full),    32'(sz == DEPTH));
    check("empty",   32'(empty),   32'(sz == 0));
    check("ovf",     32'(ovf),     32'(m_ovf));
    check("unf",     32'(unf),     32'(m_unf));
  endtask

  // One clock cycle: drive requests, clock, update model, compare mid-cycle.
  task automatic cyc(input logic w, input logic r, input logic f, input logic [WIDTH-1:0] dv);
    wr_en = w;
    rd_en = r;
    flush = f;
    d     = dv;
    @(posedge clk);
    model_step(w, r, f, dv);
    @(negedge clk);
    compare_model();
    wr_en = 1'b0;
    rd_en = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] seq [4];
    seq[0] = 16'h1111; seq[1] = 16'h2222; seq[2] = 16'h3333; seq[3] = 16'h4444;

    // Reset state, observed before any clock edge.
    #2;
    check("rst_q",     32'(q),       32'h0);
    check("rst_qv",    32'(q_valid), 32'h0);
    check("rst_empty", 32'(empty),   32'h1);
    check("rst_full",  32'(full),    32'h0);
    check("rst_count", 32'(count),   32'h0);
    check("rst_ovf",   32'(ovf),     32'h0);
    check("rst_unf",   32'(unf),     32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Fill, overflow, drain.
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, seq[i]);
    check("fill_full",  32'(full),  32'h1);
    check("fill_count", 32'(count), 32'h4);
    cyc(1'b1, 1'b0, 1'b0, 16'h5555);
    check("ovf_set",   32'(ovf),   32'h1);
    check("ovf_count", 32'(count), 32'h4);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b0, '0);
      check("drain_q",  32'(q),       32'(seq[i]));
      check("drain_qv", 32'(q_valid), 32'h1);
    end
    cyc(1'b0, 1'b0, 1'b0, '0);
    check("drain_empty", 32'(empty),   32'h1);
    check("drain_qv0",   32'(q_valid), 32'h0);
    check("drain_hold",  32'(q),       32'h4444);
    cyc(1'b0, 1'b0, 1'b1, '0);
    check("flush_ovf", 32'(ovf), 32'h0);

    // Wrap-around: 10 pushes interleaved with 10 pops.
    for (int i = 0; i < 12; i++) begin
      cyc(i < 10, i >= 2, 1'b0, WIDTH'(16'h0100 + i));
      if (i >= 2) check("wrap_q", 32'(q), 32'(16'h0100 + i - 2));
    end
    check("wrap_empty", 32'(empty), 32'h1);

    // Full plus simultaneous push/pop.
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, WIDTH'(16'h2001 + i));
    cyc(1'b1, 1'b1, 1'b0, 16'hAAAA);
    check("fullrw_q",     32'(q),     32'h2001);
    check("fullrw_count", 32'(count), 32'h4);
    check("fullrw_ovf",   32'(ovf),   32'h0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, '0);
    check("fullrw_last", 32'(q), 32'hAAAA);

    // Empty plus simultaneous push/pop.
    cyc(1'b1, 1'b1, 1'b0, 16'hBEEF);
    check("emprw_unf",   32'(unf),     32'h1);
    check("emprw_q",     32'(q),       32'hAAAA);
    check("emprw_qv",    32'(q_valid), 32'h0);
    check("emprw_count", 32'(count),   32'h1);
    cyc(1'b0, 1'b1, 1'b0, '0);
    check("emprw_pop", 32'(q), 32'hBEEF);

    // Flush with data queued.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, WIDTH'(16'h3001 + i));
    cyc(1'b0, 1'b0, 1'b1, '0);
    check("flush_count", 32'(count), 32'h0);
    check("flush_empty", 32'(empty), 32'h1);
    check("flush_unf",   32'(unf),   32'h0);
    check("flush_q",     32'(q),     32'hBEEF);

    // Asynchronous reset pulse between edges with two words queued.
    cyc(1'b1, 1'b0, 1'b0, 16'h4001);
    cyc(1'b1, 1'b0, 1'b0, 16'h4002);
    #1 rst = 1'b0;
    #1;
    model_reset();
    check("arst_q",     32'(q),     32'h0);
    check("arst_count", 32'(count), 32'h0);
    check("arst_empty", 32'(empty), 32'h1);
    #1 rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 16'h7777);
    cyc(1'b0, 1'b1, 1'b0, '0);
    check("arst_first", 32'(q), 32'h7777);

    // Requests ignored while reset is held across an edge.
    rst = 1'b0;
    model_reset();
    cyc(1'b1, 1'b1, 1'b0, 16'h9999);
    check("rsthold_count", 32'(count), 32'h0);
    check("rsthold_unf",   32'(unf),   32'h0);
    rst = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, '0);
    check("rsthold_q", 32'(q), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
